fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 32-bit five-type pipeline; produces `Instruction`, `PC_Reg` and `PC_Next` for the decode cycle.
- Owns the PC register and the instruction-memory request/ack handshake.
- Holds a one-entry skid buffer plus the IF/ID pipeline register.
- Accepts redirects from decode (jump/branch targets selected by pcSrc) and halts on the stop bit (`Instruction[31]`).

Parameters:
- RESET_PC, 32'h00000000, PC loaded at reset.
- PC_STEP, 1, sequential increment (word-addressed PC).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory response valid; ignored while imem_req=0.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- stall  in  1  decode cannot accept; IF/ID register holds.
- redirect  in  1  decode requests PC change.
- pc_src  in  2  01 sequential (no redirect), 10 jump, 11 branch/register target; 00 reserved (no redirect).
- jump_target  in  32  target used when pc_src=10.
- branch_target  in  32  target used when pc_src=11.
- Instruction  out  32  IF/ID instruction.
- PC_Reg  out  32  address of Instruction.
- PC_Next  out  32  PC_Reg+PC_STEP, mod 2^32.
- if_valid  out  1  IF/ID holds a live instruction.
- halted  out  1  stop instruction fetched; no further requests.

Behaviour:
- Reset (rst=0 at edge):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0; Instruction, PC_Reg, PC_Next=0; if_valid=0; halted=0; skid empty.
  - Any outstanding request is abandoned; an ack arriving after reset while imem_req=0 is ignored.
- States: IDLE, FETCH, SKID, SQUASH, HALT.
- IDLE: imem_req=0; next state FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On ack, the word is accepted:
  - stall=0: IF/ID <= {rdata, pc, pc+PC_STEP}, if_valid=1, pc <= pc+PC_STEP.
  - stall=1: word and pc go to the skid buffer, pc <= pc+PC_STEP, state SKID; imem_req=0 next cycle.
  - Accepted word has rdata[31]=1: state HALT instead of FETCH/SKID (from SKID the HALT entry is deferred until the skid entry drains). The stop instruction is still delivered.
- No ack and stall=0: if_valid <= 0 (bubble).
- stall=1: IF/ID register and if_valid hold their values.
- SKID: imem_req=0. When stall=0, IF/ID <= skid entry, if_valid=1, skid empties, next state FETCH (or HALT if that entry had bit31=1).
- HALT: imem_req=0, halted=1; IF/ID drains normally (if_valid clears once stall=0 and the entry is consumed).
- Redirect (redirect=1 and pc_src in {10,11}) has the highest priority, above stall and ack:
  - pc <= selected target; if_valid <= 0; skid cleared; halted <= 0.
  - From FETCH with no ack this cycle: state SQUASH.
  - From FETCH with ack this cycle: the data is discarded and state goes to FETCH at the target.
  - From IDLE, SKID or HALT: state FETCH. A speculatively fetched stop instruction is cancelled.
- SQUASH: imem_req stays 1 with the old imem_addr (requests cannot be aborted) until ack. The data is discarded, then state FETCH at the redirected pc. A further redirect in SQUASH only updates pc.
- Redirect with pc_src=01 or 00: no effect.
- Wrap-around: pc 32'hFFFFFFFF with step 1 gives next pc 0 and PC_Next=0; no flag.
- Latency: ack at edge N puts Instruction on the outputs after edge N (visible in cycle N+1). Zero-wait memory sustains 1 instruction/cycle.

Test Plan:
- Reset with RESET_PC=0, memory acks every cycle returning addr+32'h100 → after IDLE, PC_Reg=0,1,2 with Instruction=32'h100,101,102 on consecutive cycles; PC_Next=PC_Reg+1; if_valid=1.
- stall=1 for 3 cycles while ack returns at pc=5 → IF/ID holds pc=4, word for 5 in skid, imem_req=0; stall=0 → PC_Reg=5 next cycle, then fetch resumes at 6.
- Ack delayed 2 cycles at pc=8; redirect, pc_src=10, jump_target=32'h40 in first wait cycle → SQUASH, old ack data discarded, next imem_addr=32'h40, if_valid=0 throughout.
- Word 32'h80000000 fetched at pc=3 → delivered as PC_Reg=3, halted=1, imem_req=0 thereafter; then redirect pc_src=11, branch_target=32'h20 → halted=0, fetch at 32'h20.
- RESET_PC=32'hFFFFFFFF → first PC_Next=0, second fetch imem_addr=0.
- rst=0 mid-FETCH with ack pending → imem_req=0 and all outputs zero after the edge; a late ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, issues word requests to instruction
//   memory, parks one word in a skid entry when decode stalls, and presents
//   the IF/ID register (Instruction, PC_Reg, PC_Next, if_valid) to decode.
//   Redirects from decode (pc_src 10 = jump, 11 = branch/register) override
//   everything else. A fetched word with bit 31 set stops further fetching.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   imem_req/imem_addr  fetch request and its address
//   imem_ack/imem_rdata memory response; ack ignored while imem_req=0
//   stall               decode cannot accept; IF/ID holds
//   redirect, pc_src    PC change request and target select
//   jump_target         target for pc_src=10
//   branch_target       target for pc_src=11
//   Instruction, PC_Reg, PC_Next, if_valid   IF/ID register contents
//   halted              stop instruction fetched, no further requests
//   dbg_state           current FSM state (observability only)
//
// Handshake: a memory transfer happens on a rising edge where imem_req=1 and
// imem_ack=1. While imem_req=1 and no ack has arrived, imem_addr is held
// stable; a request once raised is never withdrawn until acked (reset aside).
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Reg,
  output logic [31:0] PC_Next,
  output logic        if_valid,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SKID   = 3'd2,
    S_SQUASH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;   // address of the request left in flight by a redirect
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_reg;
  logic [31:0] r_pc_next;
  logic        r_if_valid;

  state_t      w_next_state;
  logic        w_redir;
  logic [31:0] w_target;
  logic        w_ack;
  logic        w_load_fetch;
  logic        w_load_skid;
  logic        w_fill_skid;
  logic        w_advance_pc;
  logic        w_park_addr;

  // Only pc_src 10/11 redirect; 01 and 00 are treated as no redirect.
  assign w_redir  = redirect && pc_src[1];
  assign w_target = pc_src[0] ? branch_target : jump_target;

  assign imem_req  = (r_state == S_FETCH) || (r_state == S_SQUASH);
  // In SQUASH the old request is still outstanding, so its address is kept
  // on the bus while r_pc already holds the redirect target.
  assign imem_addr = (r_state == S_SQUASH) ? r_req_addr : r_pc;
  assign w_ack     = imem_ack && imem_req;

  assign Instruction = r_instr;
  assign PC_Reg      = r_pc_reg;
  assign PC_Next     = r_pc_next;
  assign if_valid    = r_if_valid;
  assign halted      = (r_state == S_HALT);
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load_fetch = 1'b0;
    w_load_skid  = 1'b0;
    w_fill_skid  = 1'b0;
    w_advance_pc = 1'b0;
    w_park_addr  = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_redir) begin
          // Acked data for the old path is simply dropped.
          w_next_state = w_ack ? S_FETCH : S_SQUASH;
          w_park_addr  = !w_ack;
        end else if (w_ack) begin
          w_advance_pc = 1'b1;
          if (stall) begin
            // A stop word parked here defers HALT until it drains.
            w_fill_skid  = 1'b1;
            w_next_state = S_SKID;
          end else begin
            w_load_fetch = 1'b1;
            w_next_state = imem_rdata[31] ? S_HALT : S_FETCH;
          end
        end
      end
      S_SKID: begin
        if (w_redir) begin
          w_next_state = S_FETCH;
        end else if (!stall) begin
          w_load_skid  = 1'b1;
          w_next_state = r_skid_instr[31] ? S_HALT : S_FETCH;
        end
      end
      S_SQUASH: if (w_ack) w_next_state = S_FETCH;
      S_HALT:   if (w_redir) w_next_state = S_FETCH;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= 32'h0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= 32'h0;
      r_instr      <= 32'h0;
      r_pc_reg     <= 32'h0;
      r_pc_next    <= 32'h0;
      r_if_valid   <= 1'b0;
    end else begin
      if (w_redir)           r_pc <= w_target;
      else if (w_advance_pc) r_pc <= r_pc + PC_STEP;

      if (w_park_addr) r_req_addr <= r_pc;

      if (w_fill_skid) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_pc;
      end

      if (w_redir) begin
        r_if_valid <= 1'b0;
      end else if (w_load_fetch) begin
        r_instr    <= imem_rdata;
        r_pc_reg   <= r_pc;
        r_pc_next  <= r_pc + PC_STEP;
        r_if_valid <= 1'b1;
      end else if (w_load_skid) begin
        r_instr    <= r_skid_instr;
        r_pc_reg   <= r_skid_pc;
        r_pc_next  <= r_skid_pc + PC_STEP;
        r_if_valid <= 1'b1;
      end else if (!stall) begin
        // Entry consumed (or nothing arrived): bubble.
        r_if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (RESET_PC = 0) ----------------
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [1:0]  pc_src;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic        if_valid;
  logic        halted;
  logic [2:0]  dbg_state;

  fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd1)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .pc_src(pc_src),
    .jump_target(jump_target), .branch_target(branch_target),
    .Instruction(instr), .PC_Reg(pc_reg), .PC_Next(pc_next),
    .if_valid(if_valid), .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- second DUT for PC wrap-around ----------------
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_ack;
  logic [31:0] wr_rdata;
  logic [31:0] wr_instr;
  logic [31:0] wr_pc_reg;
  logic [31:0] wr_pc_next;
  logic        wr_valid;
  logic        wr_halted;
  logic [2:0]  wr_dbg;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .PC_STEP(32'd1)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_ack(wr_ack), .imem_rdata(wr_rdata),
    .stall(1'b0), .redirect(1'b0), .pc_src(2'b01),
    .jump_target(32'h0), .branch_target(32'h0),
    .Instruction(wr_instr), .PC_Reg(wr_pc_reg), .PC_Next(wr_pc_next),
    .if_valid(wr_valid), .halted(wr_halted), .dbg_state(wr_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_total;
  int n_bad;

  // memory model: mode 0 returns addr+0x100 (optional stop word at stop_addr),
  // mode 1 returns a scrambled word with bit 31 set when addr[4:0]==19
  int          mem_mode;
  logic        stop_en;
  logic [31:0] stop_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [30:0] h;
    if (mem_mode == 0) begin
      if (stop_en && a == stop_addr) return 32'h8000_0000;
      return a + 32'h100;
    end
    h = a[30:0] * 31'd2654435 + 31'h1234567;
    return {(a[4:0] == 5'd19), h};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive this cycle's inputs, advance one cycle,
  // return at the next falling edge.
  task automatic tick(input logic ack, input logic stl, input logic rd,
                      input logic [1:0] src, input logic [31:0] jt,
                      input logic [31:0] bt);
    imem_ack      = ack;
    imem_rdata    = mem_word(imem_addr);
    stall         = stl;
    redirect      = rd;
    pc_src        = src;
    jump_target   = jt;
    branch_target = bt;
    wr_ack        = wr_req;
    wr_rdata      = wr_addr + 32'h100;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_run();
    tick(imem_req, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_total++;
    if ({imem_req, if_valid, halted} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got req/valid/halted=%b want 000", {imem_req, if_valid, halted});
    end
    n_total++;
    if ({instr, pc_reg, pc_next} !== 96'h0) begin
      n_bad++; $display("FAIL reset_ifid: got %h %h %h want all zero", instr, pc_reg, pc_next);
    end
    n_total++;
    if ({wr_req, wr_valid, wr_pc_reg} !== 34'h0) begin
      n_bad++; $display("FAIL reset_wrap_dut: got req=%b valid=%b pc_reg=%h want 0", wr_req, wr_valid, wr_pc_reg);
    end
  endtask

  task automatic test_wrap();
    tick_run();
    n_total++;
    if ({wr_req, wr_addr} !== {1'b1, 32'hFFFF_FFFF}) begin
      n_bad++; $display("FAIL wrap_first_addr: got req=%b addr=%h want 1 ffffffff", wr_req, wr_addr);
    end
    tick_run();
    n_total++;
    if ({wr_valid, wr_pc_reg, wr_pc_next, wr_instr} !== {1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_00FF}) begin
      n_bad++; $display("FAIL wrap_ifid: got v=%b pc=%h next=%h ins=%h want 1 ffffffff 0 ff", wr_valid, wr_pc_reg, wr_pc_next, wr_instr);
    end
    n_total++;
    if ({wr_req, wr_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL wrap_second_addr: got req=%b addr=%h want 1 0", wr_req, wr_addr);
    end
    tick_run();
    n_total++;
    if ({wr_pc_reg, wr_instr} !== {32'h0, 32'h100}) begin
      n_bad++; $display("FAIL wrap_second_ifid: got pc=%h ins=%h want 0 100", wr_pc_reg, wr_instr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick_run();
    n_total++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL stream_first_req: got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, if_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick_run();
      n_total++;
      if ({if_valid, pc_reg, instr, pc_next} !== {1'b1, 32'(i), 32'(i) + 32'h100, 32'(i) + 32'h1}) begin
        n_bad++; $display("FAIL stream_%0d: got v=%b pc=%h ins=%h next=%h want 1 %h %h %h", i, if_valid, pc_reg, instr, pc_next, 32'(i), 32'(i) + 32'h100, 32'(i) + 32'h1);
      end
    end
  endtask

  task automatic test_skid();
    n_total++;
    if (imem_addr !== 32'h5) begin
      n_bad++; $display("FAIL skid_pre_addr: got %h want 5", imem_addr);
    end
    tick(imem_req, 1'b1, 1'b0, 2'b01, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({if_valid, pc_reg, imem_req} !== {1'b1, 32'h4, 1'b0}) begin
        n_bad++; $display("FAIL skid_hold_%0d: got v=%b pc=%h req=%b want 1 4 0", k, if_valid, pc_reg, imem_req);
      end
      if (k < 2) tick(1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'h0);
    end
    tick(1'b0, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    n_total++;
    if ({if_valid, pc_reg, instr, pc_next, imem_req, imem_addr} !== {1'b1, 32'h5, 32'h105, 32'h6, 1'b1, 32'h6}) begin
      n_bad++; $display("FAIL skid_drain: got v=%b pc=%h ins=%h next=%h req=%b addr=%h want 1 5 105 6 1 6", if_valid, pc_reg, instr, pc_next, imem_req, imem_addr);
    end
    tick_run();
    n_total++;
    if ({if_valid, pc_reg, instr} !== {1'b1, 32'h6, 32'h106}) begin
      n_bad++; $display("FAIL skid_resume: got v=%b pc=%h ins=%h want 1 6 106", if_valid, pc_reg, instr);
    end
  endtask

  task automatic test_squash();
    tick_run();
    n_total++;
    if (imem_addr !== 32'h8) begin
      n_bad++; $display("FAIL squash_pre_addr: got %h want 8", imem_addr);
    end
    tick(1'b0, 1'b0, 1'b1, 2'b10, 32'h40, 32'h0);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h8, 1'b0}) begin
        n_bad++; $display("FAIL squash_wait_%0d: got req=%b addr=%h v=%b want 1 8 0", k, imem_req, imem_addr, if_valid);
      end
      if (k == 0) tick(1'b0, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    n_total++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h40, 1'b0}) begin
      n_bad++; $display("FAIL squash_retarget: got req=%b addr=%h v=%b want 1 40 0", imem_req, imem_addr, if_valid);
    end
    tick_run();
    n_total++;
    if ({if_valid, pc_reg, instr} !== {1'b1, 32'h40, 32'h140}) begin
      n_bad++; $display("FAIL squash_target_ifid: got v=%b pc=%h ins=%h want 1 40 140", if_valid, pc_reg, instr);
    end
  endtask

  task automatic test_halt();
    stop_en   = 1'b1;
    stop_addr = 32'h3;
    // redirect in the same cycle as an ack: data dropped, fetch at target
    tick(imem_req, 1'b0, 1'b1, 2'b10, 32'h1, 32'h0);
    n_total++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h1}) begin
      n_bad++; $display("FAIL ack_redirect: got v=%b req=%b addr=%h want 0 1 1", if_valid, imem_req, imem_addr);
    end
    tick_run();
    tick_run();
    tick_run();
    n_total++;
    if ({if_valid, pc_reg, instr, halted, imem_req} !== {1'b1, 32'h3, 32'h8000_0000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL halt_deliver: got v=%b pc=%h ins=%h halted=%b req=%b want 1 3 80000000 1 0", if_valid, pc_reg, instr, halted, imem_req);
    end
    tick_run();
    tick_run();
    n_total++;
    if ({if_valid, halted, imem_req} !== 3'b010) begin
      n_bad++; $display("FAIL halt_idle: got v/halted/req=%b want 010", {if_valid, halted, imem_req});
    end
    tick(1'b0, 1'b0, 1'b1, 2'b01, 32'h55, 32'h55);
    n_total++;
    if ({halted, imem_req} !== 2'b10) begin
      n_bad++; $display("FAIL halt_src01_ignored: got halted/req=%b want 10", {halted, imem_req});
    end
    tick(1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h20);
    n_total++;
    if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
      n_bad++; $display("FAIL halt_branch_exit: got halted=%b req=%b addr=%h want 0 1 20", halted, imem_req, imem_addr);
    end
    tick_run();
    n_total++;
    if ({if_valid, pc_reg, instr} !== {1'b1, 32'h20, 32'h120}) begin
      n_bad++; $display("FAIL halt_branch_ifid: got v=%b pc=%h ins=%h want 1 20 120", if_valid, pc_reg, instr);
    end
    stop_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h21}) begin
      n_bad++; $display("FAIL rmid_pending: got req=%b addr=%h want 1 21", imem_req, imem_addr);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    rst = 1'b1;
    n_total++;
    if ({imem_req, if_valid, halted, instr, pc_reg, pc_next} !== 99'h0) begin
      n_bad++; $display("FAIL rmid_outputs: got req=%b v=%b h=%b ins=%h pc=%h next=%h want all zero", imem_req, if_valid, halted, instr, pc_reg, pc_next);
    end
    // late ack while no request is outstanding must be ignored
    tick(1'b1, 1'b0, 1'b0, 2'b01, 32'h0, 32'h0);
    n_total++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL rmid_late_ack: got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, if_valid);
    end
    tick_run();
    n_total++;
    if ({if_valid, pc_reg, instr} !== {1'b1, 32'h0, 32'h100}) begin
      n_bad++; $display("FAIL rmid_restart: got v=%b pc=%h ins=%h want 1 0 100", if_valid, pc_reg, instr);
    end
  endtask

  // Reference model: decode sees the architectural instruction stream. Each
  // consumed entry must be the next pc in program order (pc+1 unless a
  // redirect chose a target), carry mem(pc), and nothing may follow a stop
  // word until a redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        exp_halted;
    logic [31:0] exp_word;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic        a, s, r;
    logic [1:0]  src;
    logic [31:0] jt, bt;
    int          consumed;
    int          idle;
    int          max_idle;
    mem_mode = 1;
    do_reset();
    exp_pc = 32'h0; exp_halted = 1'b0; prev_pending = 1'b0; prev_addr = 32'h0;
    consumed = 0; idle = 0; max_idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_pending) begin
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
          n_bad++; $display("FAIL rnd_req_stable cyc=%0d: got req=%b addr=%h want 1 %h", cyc, imem_req, imem_addr, prev_addr);
        end
      end
      if (if_valid === 1'b1 && instr[31] === 1'b1) begin
        n_total++;
        if ({halted, imem_req} !== 2'b10) begin
          n_bad++; $display("FAIL rnd_stop_halts cyc=%0d: got halted/req=%b want 10", cyc, {halted, imem_req});
        end
      end
      a   = imem_req && ($urandom_range(0, 9) < 6);
      s   = ($urandom_range(0, 9) < 3);
      r   = ($urandom_range(0, 99) < 4);
      src = 2'($urandom_range(0, 3));
      jt  = 32'($urandom_range(0, 63));
      bt  = 32'($urandom_range(0, 63));
      if (if_valid === 1'b1 && !s) begin
        exp_word = mem_word(exp_pc);
        n_total++;
        if (exp_halted || {pc_reg, instr, pc_next} !== {exp_pc, exp_word, exp_pc + 32'h1}) begin
          n_bad++; $display("FAIL rnd_consume cyc=%0d: got pc=%h ins=%h next=%h want pc=%h ins=%h next=%h after_stop=%b", cyc, pc_reg, instr, pc_next, exp_pc, exp_word, exp_pc + 32'h1, exp_halted);
        end
        exp_halted = exp_word[31];
        exp_pc     = exp_pc + 32'h1;
        consumed++;
        idle = 0;
      end else if (!exp_halted) begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
      if (r && src[1]) begin
        exp_pc     = src[0] ? bt : jt;
        exp_halted = 1'b0;
        idle       = 0;
      end
      prev_pending = imem_req && !a;
      prev_addr    = imem_addr;
      tick(a, s, r, src, jt, bt);
    end
    n_total++;
    if (consumed < 300 || max_idle > 100) begin
      n_bad++; $display("FAIL rnd_progress: got consumed=%0d max_idle=%0d want >=300 and <=100", consumed, max_idle);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_total = 0; n_bad = 0;
    mem_mode = 0; stop_en = 1'b0; stop_addr = 32'h0;
    rst = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; redirect = 1'b0;
    pc_src = 2'b01; jump_target = 32'h0; branch_target = 32'h0;
    wr_ack = 1'b0; wr_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_stream();
    test_skid();
    test_squash();
    test_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
